// File: rtl/req_pending_sched.sv
// Pending-request scheduler: latches request pulses into a sticky vector and offers the
// highest pending index downstream through a registered valid/ready output stage.
module req_pending_sched #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DCW   = 8,
   localparam int unsigned IDXW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] set_in,
   input  logic             flush,
   output logic [IDXW-1:0]  out_idx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             pend_any,
   output logic [DCW-1:0]   drop_cnt
);

   typedef enum logic {StIdle, StHold} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic [IDXW-1:0]  out_idx_q, out_idx_d;
   logic [DCW-1:0]   drop_cnt_q, drop_cnt_d;

   logic [IDXW-1:0]  win_idx;
   logic [WIDTH-1:0] win_mask;
   logic             win_valid;
   logic             load;
   logic [WIDTH-1:0] load_mask;
   logic             drop_hit;

   // Ascending scan so the last hit, i.e. the highest set bit, wins.
   always_comb begin
      win_idx  = '0;
      win_mask = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (pend_q[i]) begin
            win_idx  = IDXW'(i);
            win_mask = WIDTH'(1) << i;
         end
      end
   end

   assign win_valid = |pend_q;

   always_comb begin
      state_d    = state_q;
      load       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (win_valid) begin
               load    = 1'b1;
               state_d = StHold;
            end
         end
         StHold: begin
            if (out_ready) begin
               if (win_valid) begin
                  load = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      load_mask = load ? win_mask : '0;
      // A set on the bit being loaded is a fresh request, not a collision.
      drop_hit  = |(set_in & pend_q & ~load_mask);
      pend_d    = (pend_q & ~load_mask) | set_in;
      out_idx_d = load ? win_idx : out_idx_q;

      drop_cnt_d = drop_cnt_q;
      if (drop_hit && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + DCW'(1);
      end

      if (flush) begin
         pend_d     = '0;
         state_d    = StIdle;
         drop_cnt_d = drop_cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         pend_q     <= '0;
         out_idx_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         out_idx_q  <= out_idx_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign out_idx   = out_idx_q;
   assign out_valid = (state_q == StHold);
   assign pend_any  = |pend_q;
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_req_pending_sched.sv
// Directed bench for req_pending_sched: a WIDTH=64 instance plus a WIDTH=5 instance.
module tb_req_pending_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] set_in;
   logic        flush;
   logic        out_ready;
   logic [5:0]  out_idx;
   logic        out_valid;
   logic        pend_any;
   logic [7:0]  drop_cnt;

   logic [4:0]  set5;
   logic        flush5;
   logic        ready5;
   logic [2:0]  idx5;
   logic        valid5;
   logic        pany5;
   logic [7:0]  drop5;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   req_pending_sched #(.WIDTH(64), .DCW(8)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .set_in   (set_in),
      .flush    (flush),
      .out_idx  (out_idx),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .pend_any (pend_any),
      .drop_cnt (drop_cnt)
   );

   req_pending_sched #(.WIDTH(5), .DCW(8)) u_dut5 (
      .clk      (clk),
      .rst      (rst),
      .set_in   (set5),
      .flush    (flush5),
      .out_idx  (idx5),
      .out_valid(valid5),
      .out_ready(ready5),
      .pend_any (pany5),
      .drop_cnt (drop5)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic v, input logic [5:0] idx);
      check({tag, "_valid"}, 64'(out_valid), 64'(v));
      if (v) check({tag, "_idx"}, 64'(out_idx), 64'(idx));
   endtask

   initial begin
      rst = 1'b1; set_in = '0; flush = 1'b0; out_ready = 1'b0;
      set5 = '0; flush5 = 1'b0; ready5 = 1'b0;
      tick(); tick();
      check("rst_idx", 64'(out_idx), 64'd0);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_pany", 64'(pend_any), 64'd0);
      check("rst_drop", 64'(drop_cnt), 64'd0);
      rst = 1'b0;

      // Idle with no requests.
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_valid", 64'(out_valid), 64'd0);
         check("idle_pany", 64'(pend_any), 64'd0);
         check("idle_drop", 64'(drop_cnt), 64'd0);
      end

      // Three requests, drained back to back highest first.
      out_ready = 1'b1;
      set_in = (64'd1 << 5) | (64'd1 << 40) | (64'd1 << 63);
      tick();
      set_in = '0;
      check("b2b_n1_pany", 64'(pend_any), 64'd1);
      check_out("b2b_n1", 1'b0, 6'd0);
      tick(); check_out("b2b_n2", 1'b1, 6'd63);
      tick(); check_out("b2b_n3", 1'b1, 6'd40);
      tick(); check_out("b2b_n4", 1'b1, 6'd5);
      check("b2b_n4_pany", 64'(pend_any), 64'd0);
      tick(); check_out("b2b_end", 1'b0, 6'd0);

      // Stall holds index 3; a later request for 9 follows once accepted.
      out_ready = 1'b0;
      set_in = 64'd1 << 3;
      tick();
      set_in = '0;
      tick(); check_out("stall_load", 1'b1, 6'd3);
      for (int i = 0; i < 4; i++) begin
         tick(); check_out("stall_hold", 1'b1, 6'd3);
      end
      set_in = 64'd1 << 9;
      tick();
      set_in = '0;
      check_out("stall_set9", 1'b1, 6'd3);
      check("stall_set9_pany", 64'(pend_any), 64'd1);
      out_ready = 1'b1;
      tick(); check_out("stall_acc9", 1'b1, 6'd9);
      tick(); check_out("stall_end", 1'b0, 6'd0);

      // Collisions on pending bit 7 while output holds 20.
      out_ready = 1'b0;
      set_in = 64'd1 << 20;
      tick();
      set_in = 64'd1 << 7;
      tick(); check_out("drop_hold20", 1'b1, 6'd20);
      check("drop_first", 64'(drop_cnt), 64'd0);
      tick();
      tick();
      set_in = '0;
      check("drop_two", 64'(drop_cnt), 64'd2);
      out_ready = 1'b1;
      tick(); check_out("drop_deliver7", 1'b1, 6'd7);
      check("drop_pany", 64'(pend_any), 64'd0);
      tick(); check_out("drop_once", 1'b0, 6'd0);
      check("drop_kept", 64'(drop_cnt), 64'd2);

      // Re-request of the held index 12 is a new request, not a drop.
      out_ready = 1'b0;
      set_in = 64'd1 << 12;
      tick();
      set_in = '0;
      tick(); check_out("rereq_hold", 1'b1, 6'd12);
      check("rereq_pany0", 64'(pend_any), 64'd0);
      set_in = 64'd1 << 12;
      tick();
      set_in = '0;
      check("rereq_pany1", 64'(pend_any), 64'd1);
      check("rereq_drop", 64'(drop_cnt), 64'd2);
      out_ready = 1'b1;
      tick(); check_out("rereq_again", 1'b1, 6'd12);
      tick(); check_out("rereq_end", 1'b0, 6'd0);
      check("rereq_drop2", 64'(drop_cnt), 64'd2);

      // Set and load of the same bit: stays pending, no drop.
      set_in = 64'd1 << 30;
      tick();
      tick(); check_out("setload_1", 1'b1, 6'd30);
      check("setload_pany", 64'(pend_any), 64'd1);
      check("setload_drop", 64'(drop_cnt), 64'd2);
      set_in = '0;
      tick(); check_out("setload_2", 1'b1, 6'd30);
      tick(); check_out("setload_end", 1'b0, 6'd0);

      // Flush during stall; set_in in the flush cycle is discarded.
      out_ready = 1'b0;
      set_in = 64'h1E;
      tick();
      set_in = '0;
      tick(); check_out("flush_hold", 1'b1, 6'd4);
      flush = 1'b1;
      set_in = 64'd1 << 50;
      tick();
      flush = 1'b0;
      set_in = '0;
      check_out("flush_valid", 1'b0, 6'd0);
      check("flush_pany", 64'(pend_any), 64'd0);
      check("flush_drop", 64'(drop_cnt), 64'd2);
      tick(); check_out("flush_after", 1'b0, 6'd0);
      check("flush_after_pany", 64'(pend_any), 64'd0);

      // Drop counter saturation.
      set_in = 64'd1 << 10;
      tick();
      set_in = 64'd1 << 11;
      tick();
      for (int i = 0; i < 260; i++) tick();
      set_in = '0;
      check("sat_hold", 64'(out_idx), 64'd10);
      check("sat_drop", 64'(drop_cnt), 64'd255);
      tick();
      check("sat_stay", 64'(drop_cnt), 64'd255);

      // Reset mid-handshake clears everything including drop_cnt.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst2_valid", 64'(out_valid), 64'd0);
      check("rst2_pany", 64'(pend_any), 64'd0);
      check("rst2_drop", 64'(drop_cnt), 64'd0);
      check("rst2_idx", 64'(out_idx), 64'd0);

      // WIDTH=5 instance.
      ready5 = 1'b1;
      set5 = 5'b10011;
      tick();
      set5 = '0;
      check("w5_n1_valid", 64'(valid5), 64'd0);
      tick();
      check("w5_a_valid", 64'(valid5), 64'd1);
      check("w5_a_idx", 64'(idx5), 64'd4);
      tick();
      check("w5_b_idx", 64'(idx5), 64'd1);
      tick();
      check("w5_c_idx", 64'(idx5), 64'd0);
      check("w5_c_pany", 64'(pany5), 64'd0);
      tick();
      check("w5_end_valid", 64'(valid5), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/req_pending_sched.md
# req_pending_sched

Pending-request scheduler that sits in front of the priority encoder. It latches single-cycle request pulses into a sticky pending vector and feeds that vector to the encoder. Each cycle it takes the winning index, which is the highest set bit, and offers it downstream through a valid/ready handshake. When an index is loaded into the output stage, its pending bit is retired so the next winner can be presented.

## Interface
- WIDTH, 64, number of request lines; must be at least 2; non-power-of-two values are legal.
- IDXW, ceil(log2(WIDTH)), index width; derived, never overridden.
- DCW, 8, width of the saturating drop counter.

- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- set_in  in  WIDTH  request pulses; a 1 on bit i in a cycle marks request i pending.
- flush  in  1  synchronous clear of the pending vector and the output stage; does not clear drop_cnt.
- out_idx  out  IDXW  index of the offered request; registered.
- out_valid  out  1  out_idx is valid; registered.
- out_ready  in  1  downstream accepts out_idx.
- pend_any  out  1  OR of the pending vector; registered-derived.
- drop_cnt  out  DCW  saturating count of cycles in which a set_in bit hit an already-pending bit.

## Operation
- Pending vector `pend` is a WIDTH-bit register.
  - Every cycle: pend_next = (pend & ~load_mask) | set_in.
  - load_mask is a one-hot mask of the index loaded this cycle, or zero if nothing is loaded.
- Winner: the highest set bit of pend. win_valid = |pend.
- Output stage FSM has two states.
  - IDLE (out_valid=0): if win_valid, load out_idx←winner, clear that pend bit, go to HOLD. Otherwise stay in IDLE.
  - HOLD (out_valid=1), not accepted (out_ready=0): hold out_idx and out_valid stable; pend is not modified by the output stage.
  - HOLD, accepted (out_ready=1): if win_valid, reload immediately with the new winner and stay in HOLD. This back-to-back mode gives one index per cycle. Otherwise go to IDLE.
- An index held in the output stage is not in pend. If set_in re-asserts that bit, it becomes pending again and is delivered again later. This is a new request, not a drop.
- Simultaneous set and load of the same bit: set wins. The bit stays pending and is also loaded; this is not counted as a drop.
- Drop: some set_in bit is 1 where pend is 1 and that bit is not being loaded this cycle.
  - drop_cnt increments by 1 per such cycle, regardless of how many bits collide.
  - drop_cnt saturates at 2^DCW−1.
- flush: next cycle pend=0 and out_valid=0; set_in in the flush cycle is discarded. drop_cnt is held.
- rst: clears pend, out_valid, out_idx and drop_cnt; FSM goes to IDLE. All other inputs are ignored during rst.
- Priority is strict, highest index first. Low-index requests can starve; this is by design.

## Timing
- Reset values: out_idx=0, out_valid=0, pend_any=0, drop_cnt=0.
- Latency with the output idle: set_in bit in cycle N → pend bit in N+1 → out_valid=1 with that index in N+2.
- Throughput: one accepted index per cycle while pend is non-empty and out_ready=1.
- out_idx must not change while out_valid=1 and out_ready=0.
- pend_any reflects pend after the clock edge; it does not include the index held in the output stage.
- rst or flush asserted mid-handshake: out_valid drops on the next edge even if out_ready is low. The offered index is lost.
- Upper bits for non-power-of-two WIDTH: indices ≥ WIDTH are never produced.

## Test plan
- Reset, then set_in=0x0 for 10 cycles → out_valid=0, pend_any=0, drop_cnt=0 throughout.
- set_in=bit5|bit40|bit63 for one cycle, out_ready=1 held → out_idx=63, 40, 5 on cycles N+2, N+3, N+4; then out_valid=0.
- set_in=bit3, out_ready=0 for 5 cycles, then set_in=bit9 → out_idx stays 3 while stalled; after out_ready=1, out_idx is 3 then 9.
- bit7 pending and output in HOLD on another index; set_in=bit7 twice more → drop_cnt=2, and bit7 is delivered exactly once.
- bit12 held in output (stalled); set_in=bit12 → pend_any=1; after accept, 12 is delivered a second time; drop_cnt unchanged.
- Set 4 bits, flush during stall → next cycle out_valid=0, pend_any=0, drop_cnt retained.
- WIDTH=5 instance: set_in=5'b10011 → out_idx sequence 4, 1, 0; IDXW=3.
